// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and the opcode constants the control decoder also uses.
// Defining FETCH_HALT_EN adds the HALT state for branch-to-self.
package instruction_fetch_pkg;

  localparam int OPCODE_W = 11;
  localparam int INSTR_W  = 32;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ISSUE, ST_HALT} fetch_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ISSUE} fetch_state_e;
`endif

  // Full 11-bit opcodes; branch formats only decode their leading bits.
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'h7C2;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'h7C0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'h458;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'h658;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'h450;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'h550;
  localparam logic [7:0]          OP_CBZ  = 8'hB4;
  localparam logic [5:0]          OP_B    = 6'h05;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC: taken branches add the word offset, otherwise step by one word.
// Arithmetic wraps modulo 2^PC_W; Uncondbranch wins over Branch.
module fetch_next_pc
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] offset,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic taken;

  always_comb begin
    taken   = uncond_branch | (branch & zero);
    next_pc = taken ? (pc + (offset << 2)) : (pc + PC_STEP);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE -> REQ (wait imem_ack) -> ISSUE (hold until Retire) -> REQ.
// Optional FETCH_HALT_EN parks the stage in HALT on an unconditional branch-to-self.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                CLK,
  input  logic                Reset_L,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  Instruction,
  output logic [OPCODE_W-1:0] Opcode,
  output logic                InstValid,
  input  logic                Retire,
  input  logic                Branch,
  input  logic                Uncondbranch,
  input  logic                Zero,
  input  logic [PC_W-1:0]     BranchOffset,
  output logic [PC_W-1:0]     PC
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, next_pc;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                imem_req_q, imem_req_d;
  logic                inst_valid_q, inst_valid_d;

  fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc            (pc_q),
    .offset        (BranchOffset),
    .branch        (Branch),
    .uncond_branch (Uncondbranch),
    .zero          (Zero),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (Retire) begin
`ifdef FETCH_HALT_EN
          if (Uncondbranch && (BranchOffset == '0)) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
`else
          pc_d    = next_pc;
          state_d = ST_REQ;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    imem_req_d   = (state_d == ST_REQ);
    inst_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign Opcode      = opcode_of(instr_q);
  assign InstValid   = inst_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: dut_a uses RESET_PC=0, dut_b uses RESET_PC=0x100.
module tb_instruction_fetch;

  logic        CLK;
  logic        rst_a_n, rst_b_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Retire, Branch, Uncondbranch, Zero;
  logic [63:0] BranchOffset;

  logic        a_req, a_valid, b_req, b_valid;
  logic [63:0] a_addr, a_pc, b_addr, b_pc;
  logic [31:0] a_instr, b_instr;
  logic [10:0] a_opcode, b_opcode;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] W_LDUR = 32'hF8400000;
  localparam logic [31:0] W_ADD  = 32'h8B020020;
  localparam logic [31:0] W_CBZ  = 32'hB4FFFFC0;
  localparam logic [31:0] W_NOP  = 32'hD503201F;
  localparam logic [31:0] W_ADDI = 32'h91000421;

  instruction_fetch #(.PC_W(64), .RESET_PC(64'h0)) dut_a (
    .CLK(CLK), .Reset_L(rst_a_n), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instruction(a_instr),
    .Opcode(a_opcode), .InstValid(a_valid), .Retire(Retire), .Branch(Branch),
    .Uncondbranch(Uncondbranch), .Zero(Zero), .BranchOffset(BranchOffset), .PC(a_pc)
  );

  instruction_fetch #(.PC_W(64), .RESET_PC(64'h100)) dut_b (
    .CLK(CLK), .Reset_L(rst_b_n), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instruction(b_instr),
    .Opcode(b_opcode), .InstValid(b_valid), .Retire(Retire), .Branch(Branch),
    .Uncondbranch(Uncondbranch), .Zero(Zero), .BranchOffset(BranchOffset), .PC(b_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic retire(input logic br, input logic ub, input logic z, input logic [63:0] off);
    Retire = 1'b1; Branch = br; Uncondbranch = ub; Zero = z; BranchOffset = off;
    tick();
    Retire = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0; BranchOffset = '0;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    Retire = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0; BranchOffset = '0;
    tick(); tick();
    n_total++; if (a_pc !== 64'h0) $display("FAIL reset_pc got %h want 0", a_pc); else n_pass++;
    n_total++; if (a_req !== 1'b0) $display("FAIL reset_req got %b want 0", a_req); else n_pass++;
    n_total++; if (a_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", a_valid); else n_pass++;
    n_total++; if (a_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", a_instr); else n_pass++;
    n_total++; if (b_pc !== 64'h100) $display("FAIL reset_pc_b got %h want 100", b_pc); else n_pass++;
  endtask

  task automatic test_first_fetch();
    rst_a_n = 1'b1;
    n_total++; if (a_req !== 1'b0) $display("FAIL idle_req got %b want 0", a_req); else n_pass++;
    // ack already high during IDLE must not be latched there
    imem_ack = 1'b1; imem_rdata = W_LDUR;
    tick();
    n_total++; if (a_req !== 1'b1) $display("FAIL req_state got %b want 1", a_req); else n_pass++;
    n_total++; if (a_addr !== 64'h0) $display("FAIL req_addr got %h want 0", a_addr); else n_pass++;
    n_total++; if (a_instr !== 32'h0) $display("FAIL idle_ack_ignored got %h want 0", a_instr); else n_pass++;
    n_total++; if (a_valid !== 1'b0) $display("FAIL req_valid got %b want 0", a_valid); else n_pass++;
    tick();
    imem_ack = 1'b0;
    n_total++; if (a_valid !== 1'b1) $display("FAIL issue_valid got %b want 1", a_valid); else n_pass++;
    n_total++; if (a_instr !== W_LDUR) $display("FAIL issue_instr got %h want %h", a_instr, W_LDUR); else n_pass++;
    n_total++; if (a_opcode !== 11'h7C2) $display("FAIL ldur_opcode got %h want 7c2", a_opcode); else n_pass++;
    n_total++; if (a_req !== 1'b0) $display("FAIL issue_req got %b want 0", a_req); else n_pass++;
  endtask

  task automatic test_add();
    retire(1'b0, 1'b1, 1'b0, 64'd4);
    n_total++; if (a_addr !== 64'h10) $display("FAIL jump_0x10 got %h want 10", a_addr); else n_pass++;
    n_total++; if (a_valid !== 1'b0) $display("FAIL retire_valid got %b want 0", a_valid); else n_pass++;
    fetch(W_ADD);
    n_total++; if (a_opcode !== 11'h458) $display("FAIL add_opcode got %h want 458", a_opcode); else n_pass++;
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    n_total++; if (a_addr !== 64'h14) $display("FAIL add_next got %h want 14", a_addr); else n_pass++;
    n_total++; if (a_req !== 1'b1) $display("FAIL add_next_req got %b want 1", a_req); else n_pass++;
  endtask

  task automatic test_cbz();
    fetch(W_NOP);
    retire(1'b0, 1'b1, 1'b0, 64'd3);
    n_total++; if (a_addr !== 64'h20) $display("FAIL jump_0x20 got %h want 20", a_addr); else n_pass++;
    fetch(W_CBZ);
    n_total++; if (a_opcode !== 11'h5A7) $display("FAIL cbz_opcode got %h want 5a7", a_opcode); else n_pass++;
    retire(1'b1, 1'b0, 1'b1, -64'd2);
    n_total++; if (a_addr !== 64'h18) $display("FAIL cbz_taken got %h want 18", a_addr); else n_pass++;
    fetch(W_NOP);
    retire(1'b0, 1'b1, 1'b0, 64'd2);
    fetch(W_CBZ);
    retire(1'b1, 1'b0, 1'b0, -64'd2);
    n_total++; if (a_addr !== 64'h24) $display("FAIL cbz_not_taken got %h want 24", a_addr); else n_pass++;
    fetch(W_NOP);
    retire(1'b1, 1'b1, 1'b0, 64'd4);
    n_total++; if (a_addr !== 64'h34) $display("FAIL uncond_priority got %h want 34", a_addr); else n_pass++;
  endtask

  task automatic test_delayed_ack();
    for (int i = 0; i < 5; i++) begin
      Retire = 1'b1; Uncondbranch = 1'b1; BranchOffset = 64'd8;
      tick();
      n_total++; if (a_addr !== 64'h34) $display("FAIL wait_addr[%0d] got %h want 34", i, a_addr); else n_pass++;
      n_total++; if (a_valid !== 1'b0) $display("FAIL wait_valid[%0d] got %b want 0", i, a_valid); else n_pass++;
      n_total++; if (a_instr !== W_NOP) $display("FAIL wait_instr[%0d] got %h want %h", i, a_instr, W_NOP); else n_pass++;
    end
    Retire = 1'b0; Uncondbranch = 1'b0; BranchOffset = '0;
    fetch(W_ADDI);
    n_total++; if (a_instr !== W_ADDI) $display("FAIL late_ack_instr got %h want %h", a_instr, W_ADDI); else n_pass++;
    n_total++; if (a_valid !== 1'b1) $display("FAIL late_ack_valid got %b want 1", a_valid); else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    n_total++; if (a_instr !== W_ADDI) $display("FAIL issue_ack_ignored got %h want %h", a_instr, W_ADDI); else n_pass++;
    n_total++; if (a_valid !== 1'b1) $display("FAIL issue_held got %b want 1", a_valid); else n_pass++;
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    n_total++; if (a_addr !== 64'h38) $display("FAIL after_wait got %h want 38", a_addr); else n_pass++;
  endtask

  task automatic test_wrap_and_self();
    fetch(W_NOP);
    retire(1'b0, 1'b1, 1'b0, -64'd15);
    n_total++; if (a_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL jump_top got %h want fffffffffffffffc", a_addr); else n_pass++;
    fetch(W_NOP);
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    n_total++; if (a_addr !== 64'h0) $display("FAIL pc_wrap got %h want 0", a_addr); else n_pass++;
    fetch(32'h14000000);
    retire(1'b0, 1'b1, 1'b0, 64'd0);
`ifdef FETCH_HALT_EN
    n_total++; if (a_req !== 1'b0) $display("FAIL halt_req got %b want 0", a_req); else n_pass++;
    n_total++; if (a_valid !== 1'b0) $display("FAIL halt_valid got %b want 0", a_valid); else n_pass++;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (a_req !== 1'b0) $display("FAIL halt_stay[%0d] got %b want 0", i, a_req); else n_pass++;
      n_total++; if (a_pc !== 64'h0) $display("FAIL halt_pc[%0d] got %h want 0", i, a_pc); else n_pass++;
    end
    imem_ack = 1'b0;
`else
    n_total++; if (a_req !== 1'b1) $display("FAIL self_req got %b want 1", a_req); else n_pass++;
    n_total++; if (a_addr !== 64'h0) $display("FAIL self_addr got %h want 0", a_addr); else n_pass++;
    fetch(32'h14000000);
    n_total++; if (a_valid !== 1'b1) $display("FAIL self_valid got %b want 1", a_valid); else n_pass++;
    retire(1'b0, 1'b1, 1'b0, 64'd0);
    n_total++; if (a_addr !== 64'h0) $display("FAIL self_again got %h want 0", a_addr); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_issue();
    rst_b_n = 1'b1;
    tick();
    n_total++; if (b_addr !== 64'h100) $display("FAIL b_first_addr got %h want 100", b_addr); else n_pass++;
    n_total++; if (b_req !== 1'b1) $display("FAIL b_first_req got %b want 1", b_req); else n_pass++;
    fetch(W_NOP);
    retire(1'b0, 1'b1, 1'b0, -64'd48);
    n_total++; if (b_addr !== 64'h40) $display("FAIL b_jump_0x40 got %h want 40", b_addr); else n_pass++;
    fetch(W_ADD);
    n_total++; if (b_valid !== 1'b1) $display("FAIL b_issue got %b want 1", b_valid); else n_pass++;
    rst_b_n = 1'b0;
    #1;
    n_total++; if (b_pc !== 64'h100) $display("FAIL async_pc got %h want 100", b_pc); else n_pass++;
    n_total++; if (b_valid !== 1'b0) $display("FAIL async_valid got %b want 0", b_valid); else n_pass++;
    n_total++; if (b_req !== 1'b0) $display("FAIL async_req got %b want 0", b_req); else n_pass++;
    n_total++; if (b_instr !== 32'h0) $display("FAIL async_instr got %h want 0", b_instr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    rst_b_n = 1'b1;
    tick();
    n_total++; if (b_instr !== 32'h0) $display("FAIL late_ack_after_reset got %h want 0", b_instr); else n_pass++;
    n_total++; if (b_addr !== 64'h100) $display("FAIL refetch_addr got %h want 100", b_addr); else n_pass++;
    n_total++; if (b_req !== 1'b1) $display("FAIL refetch_req got %b want 1", b_req); else n_pass++;
    imem_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_add();
    test_cbz();
    test_delayed_ack();
    test_wrap_and_self();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
